// File: rtl/loopback_fifo.sv
// rtl/loopback_fifo.sv - usb_cdc echo FIFO with optional case swap and idle sleep flag
module loopback_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int IDLE_CYCLES = 'd2000,
  parameter bit CASE_SWAP   = 1'b0
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic       sleep_o
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL     = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [19:0]           IDLE_MAX = IDLE_CYCLES[19:0];
  localparam logic [19:0]           IDLE_ONE = 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [19:0]           idle_cnt;
  logic                  sleep_q;
  logic                  push;
  logic                  pop;
  logic [7:0]            wr_byte;

  // Full blocks the write even if a pop happens on the same edge.
  assign out_ready_o = (count < FULL);
  assign in_valid_o  = (count != '0);
  assign push        = out_valid_i & out_ready_o;
  assign pop         = in_valid_o & in_ready_i;
  // Empty FIFO presents zero rather than a stale (unreset) memory word.
  assign in_data_o   = in_valid_o ? mem[rd_ptr] : 8'h00;
  assign sleep_o     = sleep_q;

  // Write-side transform: flip ASCII letter case when enabled.
  always_comb begin
    wr_byte = out_data_i;
    if (CASE_SWAP) begin
      if ((out_data_i >= 8'h41) && (out_data_i <= 8'h5A)) begin
        wr_byte = out_data_i + 8'h20;
      end else if ((out_data_i >= 8'h61) && (out_data_i <= 8'h7A)) begin
        wr_byte = out_data_i - 8'h20;
      end
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_byte;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at their width.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Idle counter: cleared by traffic, counts only while empty, saturates.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idle_cnt <= '0;
      sleep_q  <= 1'b0;
    end else begin
      if (push || pop) begin
        idle_cnt <= '0;
      end else if ((count == '0) && (idle_cnt != IDLE_MAX)) begin
        idle_cnt <= idle_cnt + IDLE_ONE;
      end
      sleep_q <= (idle_cnt == IDLE_MAX);
    end
  end

endmodule

// File: tb/tb_loopback_fifo.sv
// tb/tb_loopback_fifo.sv - self-checking bench for loopback_fifo (two parameter sets)
module tb_loopback_fifo;

  logic       clk;
  logic       rstn;
  logic [7:0] out_data;
  logic       out_valid;
  logic       in_ready;

  logic       a_out_ready, a_in_valid, a_sleep;
  logic [7:0] a_in_data;
  logic       b_out_ready, b_in_valid, b_sleep;
  logic [7:0] b_in_data;

  int vectors;
  int miscompares;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         idle_a, idle_b;
  logic       sleep_a_m, sleep_b_m;
  logic [7:0] bpop_log[$];
  logic [7:0] bpush_log[$];

  localparam int IDLE = 10;
  localparam int DEPTH_A = 16;
  localparam int DEPTH_B = 4;

  loopback_fifo #(.DEPTH_LOG2(4), .IDLE_CYCLES(IDLE), .CASE_SWAP(1'b1)) dut_a (
    .clk_i(clk), .rstn_i(rstn),
    .out_data_i(out_data), .out_valid_i(out_valid), .out_ready_o(a_out_ready),
    .in_data_o(a_in_data), .in_valid_o(a_in_valid), .in_ready_i(in_ready),
    .sleep_o(a_sleep)
  );

  loopback_fifo #(.DEPTH_LOG2(2), .IDLE_CYCLES(IDLE), .CASE_SWAP(1'b0)) dut_b (
    .clk_i(clk), .rstn_i(rstn),
    .out_data_i(out_data), .out_valid_i(out_valid), .out_ready_o(b_out_ready),
    .in_data_o(b_in_data), .in_valid_o(b_in_valid), .in_ready_i(in_ready),
    .sleep_o(b_sleep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] swap_case(input logic [7:0] d);
    if (d >= 8'h41 && d <= 8'h5A) return d + 8'h20;
    if (d >= 8'h61 && d <= 8'h7A) return d - 8'h20;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    idle_a    = 0;
    idle_b    = 0;
    sleep_a_m = 1'b0;
    sleep_b_m = 1'b0;
  endtask

  task automatic check_all();
    chk("a_out_ready", a_out_ready, qa.size() < DEPTH_A);
    chk("a_in_valid", a_in_valid, qa.size() > 0);
    if (qa.size() > 0) chk("a_in_data", a_in_data, qa[0]);
    chk("a_sleep", a_sleep, sleep_a_m);
    chk("b_out_ready", b_out_ready, qb.size() < DEPTH_B);
    chk("b_in_valid", b_in_valid, qb.size() > 0);
    if (qb.size() > 0) chk("b_in_data", b_in_data, qb[0]);
    chk("b_sleep", b_sleep, sleep_b_m);
  endtask

  // One clock: predict transfers, advance the model at the edge, compare 1 time unit later.
  task automatic cycle();
    bit push_a, pop_a, push_b, pop_b;
    push_a = out_valid && (qa.size() < DEPTH_A);
    pop_a  = in_ready && (qa.size() > 0);
    push_b = out_valid && (qb.size() < DEPTH_B);
    pop_b  = in_ready && (qb.size() > 0);
    if (in_ready && b_in_valid) bpop_log.push_back(b_in_data);
    if (out_valid && b_out_ready) bpush_log.push_back(out_data);
    @(posedge clk);
    sleep_a_m = (idle_a == IDLE);
    sleep_b_m = (idle_b == IDLE);
    if (push_a || pop_a) idle_a = 0;
    else if (qa.size() == 0 && idle_a < IDLE) idle_a++;
    if (push_b || pop_b) idle_b = 0;
    else if (qb.size() == 0 && idle_b < IDLE) idle_b++;
    if (pop_a) void'(qa.pop_front());
    if (push_a) qa.push_back(swap_case(out_data));
    if (pop_b) void'(qb.pop_front());
    if (push_b) qb.push_back(out_data);
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] swap_in [3];
    logic [7:0] swap_exp [3];
    int idx;
    int pv;
    int pr;
    bit acc;

    vectors     = 0;
    miscompares = 0;
    rstn      = 1'b1;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_data  = 8'h00;
    model_reset();

    // Reset state
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out_ready", a_out_ready, 1'b1);
    chk("rst_a_in_valid", a_in_valid, 1'b0);
    chk("rst_a_sleep", a_sleep, 1'b0);
    chk("rst_a_in_data", a_in_data, 8'h00);
    chk("rst_b_out_ready", b_out_ready, 1'b1);
    chk("rst_b_in_valid", b_in_valid, 1'b0);
    @(negedge clk) rstn = 1'b1;

    // Idle: sleep after 11th edge, clears on the edge after a push
    for (int i = 1; i <= 11; i++) begin
      cycle();
      if (i == 10) chk("sleep_edge10", a_sleep, 1'b0);
      if (i == 11) chk("sleep_edge11", a_sleep, 1'b1);
    end
    out_valid = 1'b1;
    out_data  = 8'h55;
    cycle();
    out_valid = 1'b0;
    cycle();
    chk("sleep_after_push", a_sleep, 1'b0);
    chk("swap_upper_U", a_in_data, 8'h75);
    in_ready = 1'b1;
    cycle();

    // Case swap echo with 1-cycle latency
    swap_in  = '{8'h61, 8'h42, 8'h31};
    swap_exp = '{8'h41, 8'h62, 8'h31};
    for (int k = 0; k < 3; k++) begin
      out_valid = 1'b1;
      out_data  = swap_in[k];
      cycle();
      chk("swap_valid", a_in_valid, 1'b1);
      chk("swap_data", a_in_data, swap_exp[k]);
    end
    out_valid = 1'b0;
    cycle();

    // Depth-4 fill under backpressure, then drain in order
    bpop_log.delete();
    in_ready  = 1'b0;
    out_valid = 1'b1;
    idx = 1;
    for (int c = 0; c < 8; c++) begin
      out_data = 8'(idx);
      acc = b_out_ready;
      cycle();
      if (acc) idx++;
    end
    chk("b_full_ready", b_out_ready, 1'b0);
    chk("b_accepted", idx - 1, 4);
    in_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      out_valid = (idx <= 5);
      out_data  = 8'(idx);
      acc = b_out_ready && out_valid;
      cycle();
      if (acc) idx++;
    end
    chk("b_drain_count", bpop_log.size(), 5);
    for (int i = 0; i < 5 && i < bpop_log.size(); i++) chk("b_drain_order", bpop_log[i], 8'(i + 1));
    out_valid = 1'b0;
    repeat (20) cycle();

    // Streaming at count=2 across pointer wrap
    bpop_log.delete();
    bpush_log.delete();
    in_ready  = 1'b0;
    out_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      out_data = 8'hA0 + 8'(i);
      cycle();
    end
    in_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      out_data = 8'hA2 + 8'(i);
      cycle();
      chk("stream_b_valid", b_in_valid, 1'b1);
    end
    chk("stream_pop_count", bpop_log.size(), 40);
    chk("stream_occupancy", bpush_log.size() - bpop_log.size(), 2);
    for (int i = 0; i < bpop_log.size() && i < bpush_log.size(); i++) chk("stream_order", bpop_log[i], bpush_log[i]);
    out_valid = 1'b0;
    repeat (20) cycle();

    // Asynchronous reset with 3 bytes stored
    in_ready  = 1'b0;
    out_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_data = 8'h10 + 8'(i);
      cycle();
    end
    out_valid = 1'b0;
    #3 rstn = 1'b0;
    model_reset();
    #1;
    chk("async_a_in_valid", a_in_valid, 1'b0);
    chk("async_a_out_ready", a_out_ready, 1'b1);
    chk("async_a_in_data", a_in_data, 8'h00);
    chk("async_b_in_valid", b_in_valid, 1'b0);
    chk("async_b_out_ready", b_out_ready, 1'b1);
    @(negedge clk) rstn = 1'b1;
    out_valid = 1'b1;
    out_data  = 8'h7E;
    cycle();
    chk("post_rst_a_first", a_in_data, 8'h7E);
    chk("post_rst_b_first", b_in_data, 8'h7E);
    out_valid = 1'b0;
    in_ready  = 1'b1;
    repeat (3) cycle();

    // Random traffic in phases of differing valid/ready bias
    for (int ph = 0; ph < 10; ph++) begin
      case (ph % 5)
        0: begin pv = 60; pr = 50; end
        1: begin pv = 90; pr = 20; end
        2: begin pv = 20; pr = 90; end
        3: begin pv = 3;  pr = 50; end
        default: begin pv = 50; pr = 50; end
      endcase
      for (int c = 0; c < 1000; c++) begin
        out_valid = ($urandom_range(0, 99) < pv);
        in_ready  = ($urandom_range(0, 99) < pr);
        out_data  = 8'($urandom);
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/loopback_fifo.md
LOOPBACK_FIFO -- requirements
Module: loopback_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4, giving FIFO depth 2**DEPTH_LOG2 bytes (legal range 1..8).
REQ-002 The block SHALL have parameter IDLE_CYCLES, default 'd2000, giving the idle clock count before sleep_o asserts (legal range 1..2**20-1).
REQ-003 The block SHALL have parameter CASE_SWAP, default 0; 1 swaps ASCII letter case on the echo path.
REQ-004 clk_i  input  1  sole clock; shared with the usb_cdc application clock domain.
REQ-005 rstn_i  input  1  reset; asynchronous assert, active-low.
REQ-006 out_data_i  input  8  host-to-device byte from usb_cdc.
REQ-007 out_valid_i  input  1  out_data_i valid.
REQ-008 out_ready_o  output  1  block accepts out_data_i.
REQ-009 in_data_o  output  8  device-to-host byte to usb_cdc.
REQ-010 in_valid_o  output  1  in_data_o valid.
REQ-011 in_ready_i  input  1  usb_cdc accepts in_data_o.
REQ-012 sleep_o  output  1  idle indication; drives the LED heartbeat logic.

Function
REQ-013 A push SHALL occur on a rising clk_i edge where out_valid_i=1 and out_ready_o=1.
REQ-014 A pop SHALL occur on a rising clk_i edge where in_valid_o=1 and in_ready_i=1.
REQ-015 Storage: circular buffer, DEPTH_LOG2-bit write and read pointers, (DEPTH_LOG2+1)-bit occupancy count.
REQ-016 Pointers SHALL wrap from 2**DEPTH_LOG2-1 to 0 with no lost or duplicated entry.
REQ-017 out_ready_o SHALL be 1 iff count < 2**DEPTH_LOG2.
- When full, a pop in the same cycle SHALL NOT enable a push in that cycle.
REQ-018 in_valid_o SHALL be 1 iff count > 0.
REQ-019 in_data_o SHALL present the oldest entry and SHALL stay stable while in_valid_o=1 and no pop occurs.
REQ-020 Latency SHALL be 1 cycle: a byte pushed into an empty FIFO at edge N is presented with in_valid_o=1 after edge N.
REQ-021 Simultaneous push and pop with 0 < count < max SHALL leave count unchanged and preserve order.
REQ-022 Transform at write time:
- CASE_SWAP=1: bytes 8'h41..8'h5A SHALL be stored +8'h20, bytes 8'h61..8'h7A SHALL be stored -8'h20.
- All other bytes, and all bytes when CASE_SWAP=0, SHALL be stored unchanged.
REQ-023 An idle counter (20-bit, saturating at IDLE_CYCLES) SHALL clear on any edge with a push or pop, and SHALL increment on edges with neither while count=0.
REQ-024 The idle counter SHALL hold its value while count>0 with no transfer (backpressure is not idle).
REQ-025 sleep_o SHALL be a registered output, 1 iff idle counter = IDLE_CYCLES; it SHALL deassert on the edge following any push or pop.
REQ-026 out_valid_i and in_ready_i toggling with no transfer SHALL NOT affect state.

Reset
REQ-027 rstn_i=0 SHALL asynchronously clear pointers, count and idle counter, giving out_ready_o=1, in_valid_o=0, sleep_o=0, in_data_o=8'h00.
REQ-028 Reset asserted mid-transfer SHALL discard all stored bytes; no byte from before reset SHALL appear after release.
REQ-029 After rstn_i rises, the first push SHALL be accepted on the first clk_i edge.

Verification
REQ-030 Push 8'h61, 8'h42, 8'h31 with CASE_SWAP=1 and in_ready_i=1 -> in_data_o sequence 8'h41, 8'h62, 8'h31, each valid 1 cycle after its push.
REQ-031 DEPTH_LOG2=2, in_ready_i=0, out_valid_i=1 continuously with bytes 1..5 -> 4 bytes accepted and out_ready_o=0; then in_ready_i=1 -> output 1,2,3,4,5 in order with no duplicates.
REQ-032 Continuous push and pop at count=2 for 40 cycles (pointer wrap) -> count stays 2 and output equals input delayed 2 transfers.
REQ-033 IDLE_CYCLES=10, empty, no traffic -> sleep_o=1 after the 11th edge; one push -> sleep_o=0 after the next edge.
REQ-034 Assert rstn_i=0 asynchronously between edges with 3 bytes stored -> in_valid_o=0 and out_ready_o=1 immediately; after release, a new byte 8'h7E is the first output.
REQ-035 Random valid/ready stimulus (10k cycles, both parameter sets) -> scoreboard shows order preserved, no overflow, no underflow.
